// File: rtl/clause_bin_loader_if.sv
// Bundles the clause-memory read port, the clause-array write port and the
// load control/status lines of clause_bin_loader into one interface.
`timescale 1ns/1ps

interface clause_bin_loader_if #(
    parameter int NUM_CLAUSES_A_BIN = 4,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int WIDTH_C_LEN       = 5,
    parameter int WIDTH_CIDX        = 3,
    parameter int WIDTH_ADDR        = 16
);
    // load control
    logic                                   start_i;
    logic                                   abort_i;
    logic [WIDTH_ADDR-1:0]                  base_addr_i;
    logic [WIDTH_CIDX-1:0]                  num_clauses_i;
    // global clause memory read port
    logic                                   mem_rd_o;
    logic [WIDTH_ADDR-1:0]                  mem_addr_o;
    logic                                   mem_valid_i;
    logic [NUM_VARS_A_BIN*3+WIDTH_C_LEN-1:0] mem_data_i;
    // clause array write port
    logic [NUM_CLAUSES_A_BIN-1:0]           wr_o;
    logic [WIDTH_C_LEN-1:0]                 clause_len_o;
    logic [NUM_VARS_A_BIN*3-1:0]            var_value_o;
    // status
    logic                                   busy_o;
    logic                                   done_o;

    modport slave (
        input  start_i, abort_i, base_addr_i, num_clauses_i, mem_valid_i, mem_data_i,
        output mem_rd_o, mem_addr_o, wr_o, clause_len_o, var_value_o, busy_o, done_o
    );

    modport master (
        output start_i, abort_i, base_addr_i, num_clauses_i, mem_valid_i, mem_data_i,
        input  mem_rd_o, mem_addr_o, wr_o, clause_len_o, var_value_o, busy_o, done_o
    );
endinterface

// File: rtl/clause_bin_loader.sv
// Loads one bin of the clause array: fetches each clause from global memory,
// writes it into its slot, then zero-fills the remaining slots.
`timescale 1ns/1ps

module clause_bin_loader #(
    parameter int NUM_CLAUSES_A_BIN = 4,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int WIDTH_C_LEN       = 5,
    parameter int WIDTH_CIDX        = 3,
    parameter int WIDTH_ADDR        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    clause_bin_loader_if.slave   bus
);
    localparam int VAR_W  = NUM_VARS_A_BIN * 3;
    localparam int DATA_W = VAR_W + WIDTH_C_LEN;
    localparam logic [WIDTH_CIDX-1:0] NUM_SLOTS = WIDTH_CIDX'(NUM_CLAUSES_A_BIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_CIDX-1:0]    idx_q, idx_d;
    logic [WIDTH_CIDX-1:0]    n_q, n_d;
    logic [WIDTH_ADDR-1:0]    base_q, base_d;
    logic [DATA_W-1:0]        data_q, data_d;

    logic                          mem_rd_q, mem_rd_d;
    logic [WIDTH_ADDR-1:0]         mem_addr_q, mem_addr_d;
    logic [NUM_CLAUSES_A_BIN-1:0]  wr_q, wr_d;
    logic [WIDTH_C_LEN-1:0]        clause_len_q, clause_len_d;
    logic [VAR_W-1:0]              var_value_q, var_value_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [WIDTH_CIDX-1:0] idx_inc;
    logic [WIDTH_CIDX-1:0] n_clamp;

    assign idx_inc = idx_q + WIDTH_CIDX'(1);
    // Oversized bins are clamped at start so no extra reads are ever issued.
    assign n_clamp = (bus.num_clauses_i > NUM_SLOTS) ? NUM_SLOTS : bus.num_clauses_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            base_q       <= '0;
            data_q       <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            wr_q         <= '0;
            clause_len_q <= '0;
            var_value_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            base_q       <= base_d;
            data_q       <= data_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            wr_q         <= wr_d;
            clause_len_q <= clause_len_d;
            var_value_q  <= var_value_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        base_d  = base_q;
        data_d  = data_q;

        if (bus.abort_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        base_d  = bus.base_addr_i;
                        n_d     = n_clamp;
                        idx_d   = '0;
                        state_d = (n_clamp != '0) ? S_REQ : S_CLEAR;
                    end
                end
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.mem_valid_i) begin
                        data_d  = bus.mem_data_i;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    idx_d = idx_inc;
                    if (idx_inc < n_q)            state_d = S_REQ;
                    else if (idx_inc < NUM_SLOTS) state_d = S_CLEAR;
                    else                          state_d = S_DONE;
                end
                S_CLEAR: begin
                    idx_d = idx_inc;
                    if (idx_inc == NUM_SLOTS) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they belong to.
    always_comb begin
        mem_rd_d     = 1'b0;
        mem_addr_d   = '0;
        wr_d         = '0;
        clause_len_d = '0;
        var_value_d  = '0;
        busy_d       = (state_d != S_IDLE);
        done_d       = 1'b0;

        unique case (state_d)
            S_REQ: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = base_d + WIDTH_ADDR'(idx_d);
            end
            S_WRITE: begin
                wr_d         = NUM_CLAUSES_A_BIN'(1) << idx_d;
                clause_len_d = data_d[WIDTH_C_LEN-1:0];
                var_value_d  = data_d[DATA_W-1:WIDTH_C_LEN];
            end
            S_CLEAR: wr_d   = NUM_CLAUSES_A_BIN'(1) << idx_d;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_rd_o     = mem_rd_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.wr_o         = wr_q;
    assign bus.clause_len_o = clause_len_q;
    assign bus.var_value_o  = var_value_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader: a latency-programmable memory responder
// feeds the DUT and per-cycle logs of reads/writes/done are checked per scenario.
`timescale 1ns/1ps

module tb_clause_bin_loader;
    localparam int NC = 4;
    localparam int NV = 8;
    localparam int WL = 5;
    localparam int WI = 3;
    localparam int WA = 16;
    localparam int VW = NV * 3;
    localparam int DW = VW + WL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clause_bin_loader_if #(
        .NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_C_LEN(WL),
        .WIDTH_CIDX(WI), .WIDTH_ADDR(WA)
    ) bus ();

    clause_bin_loader #(
        .NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NV), .WIDTH_C_LEN(WL),
        .WIDTH_CIDX(WI), .WIDTH_ADDR(WA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            c;
        logic [NC-1:0] wr;
        logic [WL-1:0] len;
        logic [VW-1:0] vv;
    } wr_ev_t;

    typedef struct {
        int            c;
        logic [WA-1:0] a;
    } rd_ev_t;

    wr_ev_t wr_log[$];
    rd_ev_t rd_log[$];
    int     done_log[$];
    int     cyc, busy_cnt, busy_first, busy_last, bad_shape;
    int     rsp_cnt, rsp_lat;
    logic [WA-1:0] rsp_addr;
    int     total, bad;

    function automatic logic [VW-1:0] exp_var(input logic [WA-1:0] a);
        return {a[7:0], a} ^ 24'h5A5A5A;
    endfunction

    // length pattern: 2*a[3:0]+3 mod 32, e.g. 0x20->3, 0x21->5, 0xFFFF->1
    function automatic logic [DW-1:0] mem_word(input logic [WA-1:0] a);
        logic [WL-1:0] two_a;
        two_a = {a[3:0], 1'b0};
        return {exp_var(a), WL'(two_a + WL'(3))};
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        done_log.delete();
        busy_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
        bad_shape  = 0;
    endtask

    // One clock: memory responder plus logging of everything the DUT shows.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.mem_valid_i = 1'b1;
                bus.mem_data_i  = mem_word(rsp_addr);
            end
        end
        if (bus.mem_rd_o === 1'b1) begin
            rd_log.push_back('{cyc, bus.mem_addr_o});
            rsp_cnt  = rsp_lat;
            rsp_addr = bus.mem_addr_o;
        end
        if (bus.wr_o !== '0) wr_log.push_back('{cyc, bus.wr_o, bus.clause_len_o, bus.var_value_o});
        if ((bus.wr_o & (bus.wr_o - 1'b1)) != '0) bad_shape++;
        if (bus.wr_o == '0 && (bus.clause_len_o != '0 || bus.var_value_o != '0)) bad_shape++;
        if (bus.done_o === 1'b1) done_log.push_back(cyc);
        if (bus.busy_o === 1'b1) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    endtask

    // Start pulse in cycle 0, optional abort / stray start in given cycles,
    // then run to last_cyc inclusive.
    task automatic run_load(input logic [WA-1:0] base, input logic [WI-1:0] num,
                            input int lat, input int abort_at, input int start_at,
                            input int last_cyc);
        clear_logs();
        rsp_cnt           = 0;
        rsp_lat           = lat;
        cyc               = 0;
        bus.base_addr_i   = base;
        bus.num_clauses_i = num;
        bus.start_i       = 1'b1;
        bus.abort_i       = (abort_at == 0);
        while (cyc < last_cyc) begin
            step();
            bus.start_i = (cyc == start_at);
            if (cyc == start_at) begin
                bus.base_addr_i   = 16'h1234;
                bus.num_clauses_i = 3'd1;
            end
            bus.abort_i = (cyc == abort_at);
        end
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst = 1'b0;
        bus.start_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outs = 64'({bus.mem_rd_o, bus.mem_addr_o, bus.wr_o, bus.clause_len_o,
                    bus.var_value_o, bus.busy_o, bus.done_o});
        total++;
        if (outs !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        bus.start_i = 1'b0;
        rst = 1'b1;
        cyc = 0;
        clear_logs();
        step();
        step();
        outs = 64'({bus.mem_rd_o, bus.mem_addr_o, bus.wr_o, bus.clause_len_o,
                    bus.var_value_o, bus.busy_o, bus.done_o});
        total++;
        if (outs !== 64'd0 || busy_cnt != 0) begin
            bad++;
            $display("FAIL idle_outputs got %h busy_cycles=%0d want 0", outs, busy_cnt);
        end
    endtask

    // n=4, L=1, plus a start pulse in the DONE cycle that must be ignored.
    task automatic test_full_load();
        int            rc[4] = '{1, 4, 7, 10};
        int            wc[4] = '{3, 6, 9, 12};
        logic [WL-1:0] ln[4] = '{5'd3, 5'd5, 5'd7, 5'd9};
        logic [NC-1:0] one = 4'b0001;
        run_load(16'h0100, 3'd4, 1, -1, 13, 16);
        total++;
        if (rd_log.size() != 4) begin
            bad++;
            $display("FAIL full_read_count got %0d want 4", rd_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= rd_log.size()) begin
                bad++;
                $display("FAIL full_read%0d got none want c=%0d", i, rc[i]);
            end else if (rd_log[i].c != rc[i] || rd_log[i].a !== WA'(16'h0100 + i)) begin
                bad++;
                $display("FAIL full_read%0d got c=%0d a=%h want c=%0d a=%h",
                         i, rd_log[i].c, rd_log[i].a, rc[i], WA'(16'h0100 + i));
            end
            total++;
            if (i >= wr_log.size()) begin
                bad++;
                $display("FAIL full_write%0d got none want c=%0d", i, wc[i]);
            end else if (wr_log[i].c != wc[i] || wr_log[i].wr !== (one << i) ||
                         wr_log[i].len !== ln[i] || wr_log[i].vv !== exp_var(WA'(16'h0100 + i))) begin
                bad++;
                $display("FAIL full_write%0d got c=%0d wr=%b len=%0d var=%h want c=%0d wr=%b len=%0d var=%h",
                         i, wr_log[i].c, wr_log[i].wr, wr_log[i].len, wr_log[i].vv,
                         wc[i], one << i, ln[i], exp_var(WA'(16'h0100 + i)));
            end
        end
        total++;
        if (wr_log.size() != 4 || done_log.size() != 1 || (done_log.size() > 0 && done_log[0] != 13)) begin
            bad++;
            $display("FAIL full_done got writes=%0d dones=%0d first_done=%0d want 4 1 13",
                     wr_log.size(), done_log.size(), (done_log.size() > 0) ? done_log[0] : -1);
        end
        total++;
        if (busy_first != 1 || busy_last != 13 || busy_cnt != 13 || bad_shape != 0) begin
            bad++;
            $display("FAIL full_busy got first=%0d last=%0d cnt=%0d shape_err=%0d want 1 13 13 0",
                     busy_first, busy_last, busy_cnt, bad_shape);
        end
    endtask

    // n=2: two real writes then two cleared slots.
    task automatic test_partial();
        int            wc[4] = '{3, 6, 7, 8};
        logic [WL-1:0] ln[4] = '{5'd3, 5'd5, 5'd0, 5'd0};
        logic [VW-1:0] vv[4];
        logic [NC-1:0] one = 4'b0001;
        vv[0] = exp_var(16'h0020);
        vv[1] = exp_var(16'h0021);
        vv[2] = '0;
        vv[3] = '0;
        run_load(16'h0020, 3'd2, 1, -1, -1, 11);
        total++;
        if (rd_log.size() != 2 || (rd_log.size() == 2 && (rd_log[0].a !== 16'h0020 || rd_log[1].a !== 16'h0021))) begin
            bad++;
            $display("FAIL partial_reads got count=%0d want 2 at 0020,0021", rd_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wr_log.size()) begin
                bad++;
                $display("FAIL partial_write%0d got none want c=%0d", i, wc[i]);
            end else if (wr_log[i].c != wc[i] || wr_log[i].wr !== (one << i) ||
                         wr_log[i].len !== ln[i] || wr_log[i].vv !== vv[i]) begin
                bad++;
                $display("FAIL partial_write%0d got c=%0d wr=%b len=%0d var=%h want c=%0d wr=%b len=%0d var=%h",
                         i, wr_log[i].c, wr_log[i].wr, wr_log[i].len, wr_log[i].vv,
                         wc[i], one << i, ln[i], vv[i]);
            end
        end
        total++;
        if (wr_log.size() != 4 || done_log.size() != 1 || (done_log.size() > 0 && done_log[0] != 9) || bad_shape != 0) begin
            bad++;
            $display("FAIL partial_done got writes=%0d dones=%0d shape_err=%0d want 4 1(c9) 0",
                     wr_log.size(), done_log.size(), bad_shape);
        end
    endtask

    // n=0: no reads, four cleared slots on cycles 1..4, done on 5.
    task automatic test_empty();
        logic [NC-1:0] one = 4'b0001;
        run_load(16'h0700, 3'd0, 1, -1, -1, 7);
        total++;
        if (rd_log.size() != 0) begin
            bad++;
            $display("FAIL empty_reads got %0d want 0", rd_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wr_log.size()) begin
                bad++;
                $display("FAIL empty_write%0d got none want c=%0d", i, i + 1);
            end else if (wr_log[i].c != i + 1 || wr_log[i].wr !== (one << i) ||
                         wr_log[i].len !== '0 || wr_log[i].vv !== '0) begin
                bad++;
                $display("FAIL empty_write%0d got c=%0d wr=%b len=%0d var=%h want c=%0d wr=%b len=0 var=0",
                         i, wr_log[i].c, wr_log[i].wr, wr_log[i].len, wr_log[i].vv, i + 1, one << i);
            end
        end
        total++;
        if (done_log.size() != 1 || (done_log.size() > 0 && done_log[0] != 5) || busy_cnt != 5) begin
            bad++;
            $display("FAIL empty_done got dones=%0d busy_cycles=%0d want 1(c5) 5", done_log.size(), busy_cnt);
        end
    endtask

    // num_clauses_i=7 clamps to 4; L=2 gives 4 cycles per clause.
    task automatic test_clamp();
        int            rc[4] = '{1, 5, 9, 13};
        int            wc[4] = '{4, 8, 12, 16};
        logic [WL-1:0] ln[4] = '{5'd3, 5'd5, 5'd7, 5'd9};
        run_load(16'h0300, 3'd7, 2, -1, -1, 19);
        total++;
        if (rd_log.size() != 4) begin
            bad++;
            $display("FAIL clamp_read_count got %0d want 4", rd_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= rd_log.size() || i >= wr_log.size()) begin
                bad++;
                $display("FAIL clamp_slot%0d got none want read c=%0d write c=%0d", i, rc[i], wc[i]);
            end else if (rd_log[i].c != rc[i] || rd_log[i].a !== WA'(16'h0300 + i) ||
                         wr_log[i].c != wc[i] || wr_log[i].len !== ln[i]) begin
                bad++;
                $display("FAIL clamp_slot%0d got rc=%0d a=%h wc=%0d len=%0d want rc=%0d a=%h wc=%0d len=%0d",
                         i, rd_log[i].c, rd_log[i].a, wr_log[i].c, wr_log[i].len,
                         rc[i], WA'(16'h0300 + i), wc[i], ln[i]);
            end
        end
        total++;
        if (wr_log.size() != 4 || done_log.size() != 1 || (done_log.size() > 0 && done_log[0] != 17)) begin
            bad++;
            $display("FAIL clamp_done got writes=%0d dones=%0d want 4 1(c17)", wr_log.size(), done_log.size());
        end
    endtask

    task automatic test_abort();
        // abort in the WAIT of clause 1; its response lands in cycle 7 and is dropped
        run_load(16'h0400, 3'd4, 2, 6, -1, 12);
        total++;
        if (rd_log.size() != 2 || wr_log.size() != 1 || done_log.size() != 0) begin
            bad++;
            $display("FAIL abort_counts got reads=%0d writes=%0d dones=%0d want 2 1 0",
                     rd_log.size(), wr_log.size(), done_log.size());
        end
        total++;
        if (wr_log.size() > 0 && (wr_log[0].c != 4 || wr_log[0].wr !== 4'b0001 ||
                                  wr_log[0].len !== 5'd3 || wr_log[0].vv !== exp_var(16'h0400))) begin
            bad++;
            $display("FAIL abort_slot0 got c=%0d wr=%b len=%0d want c=4 wr=0001 len=3",
                     wr_log[0].c, wr_log[0].wr, wr_log[0].len);
        end
        total++;
        if (busy_first != 1 || busy_last != 6) begin
            bad++;
            $display("FAIL abort_busy got first=%0d last=%0d want 1 6", busy_first, busy_last);
        end
        // a fresh start after the abort runs normally
        run_load(16'h0500, 3'd4, 1, -1, -1, 15);
        total++;
        if (rd_log.size() != 4 || wr_log.size() != 4 || done_log.size() != 1 ||
            (done_log.size() > 0 && done_log[0] != 13) ||
            (wr_log.size() == 4 && (wr_log[3].c != 12 || wr_log[3].wr !== 4'b1000))) begin
            bad++;
            $display("FAIL abort_restart got reads=%0d writes=%0d dones=%0d want 4 4 1(c13)",
                     rd_log.size(), wr_log.size(), done_log.size());
        end
        // abort together with start in IDLE: nothing starts
        run_load(16'h0600, 3'd4, 1, 0, -1, 6);
        total++;
        if (rd_log.size() != 0 || wr_log.size() != 0 || busy_cnt != 0 || done_log.size() != 0) begin
            bad++;
            $display("FAIL abort_vs_start got reads=%0d writes=%0d busy=%0d dones=%0d want 0 0 0 0",
                     rd_log.size(), wr_log.size(), busy_cnt, done_log.size());
        end
    endtask

    // base=0xFFFF wraps to 0x0000; a stray start in WAIT must not disturb the load.
    task automatic test_wrap();
        int            wc[4] = '{3, 6, 7, 8};
        logic [WL-1:0] ln[4] = '{5'd1, 5'd3, 5'd0, 5'd0};
        logic [VW-1:0] vv[4];
        logic [NC-1:0] one = 4'b0001;
        vv[0] = exp_var(16'hFFFF);
        vv[1] = exp_var(16'h0000);
        vv[2] = '0;
        vv[3] = '0;
        run_load(16'hFFFF, 3'd2, 1, -1, 2, 11);
        total++;
        if (rd_log.size() != 2 || (rd_log.size() == 2 && (rd_log[0].a !== 16'hFFFF || rd_log[1].a !== 16'h0000))) begin
            bad++;
            $display("FAIL wrap_reads got count=%0d a0=%h a1=%h want 2 ffff 0000", rd_log.size(),
                     (rd_log.size() > 0) ? rd_log[0].a : 16'hxxxx, (rd_log.size() > 1) ? rd_log[1].a : 16'hxxxx);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wr_log.size()) begin
                bad++;
                $display("FAIL wrap_write%0d got none want c=%0d", i, wc[i]);
            end else if (wr_log[i].c != wc[i] || wr_log[i].wr !== (one << i) ||
                         wr_log[i].len !== ln[i] || wr_log[i].vv !== vv[i]) begin
                bad++;
                $display("FAIL wrap_write%0d got c=%0d wr=%b len=%0d var=%h want c=%0d wr=%b len=%0d var=%h",
                         i, wr_log[i].c, wr_log[i].wr, wr_log[i].len, wr_log[i].vv,
                         wc[i], one << i, ln[i], vv[i]);
            end
        end
        total++;
        if (done_log.size() != 1 || (done_log.size() > 0 && done_log[0] != 9)) begin
            bad++;
            $display("FAIL wrap_done got dones=%0d want 1(c9)", done_log.size());
        end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] outs;
        run_load(16'hFFFF, 3'd2, 1, -1, -1, 3);
        total++;
        if (bus.wr_o !== 4'b0001 || bus.clause_len_o !== 5'd1) begin
            bad++;
            $display("FAIL midrst_in_write got wr=%b len=%0d want 0001 1", bus.wr_o, bus.clause_len_o);
        end
        rst = 1'b0;
        #1;
        outs = 64'({bus.mem_rd_o, bus.mem_addr_o, bus.wr_o, bus.clause_len_o,
                    bus.var_value_o, bus.busy_o, bus.done_o});
        total++;
        if (outs !== 64'd0) begin
            bad++;
            $display("FAIL midrst_outputs got %h want 0", outs);
        end
        #1;
        rst = 1'b1;
        clear_logs();
        rsp_cnt  = 1;
        rsp_addr = 16'h0000;
        repeat (5) step();
        total++;
        if (rd_log.size() != 0 || wr_log.size() != 0 || done_log.size() != 0 || busy_cnt != 0) begin
            bad++;
            $display("FAIL midrst_after got reads=%0d writes=%0d dones=%0d busy=%0d want 0 0 0 0",
                     rd_log.size(), wr_log.size(), done_log.size(), busy_cnt);
        end
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        cyc               = 0;
        rsp_cnt           = 0;
        rsp_lat           = 1;
        rsp_addr          = '0;
        rst               = 1'b0;
        bus.start_i       = 1'b0;
        bus.abort_i       = 1'b0;
        bus.base_addr_i   = '0;
        bus.num_clauses_i = '0;
        bus.mem_valid_i   = 1'b0;
        bus.mem_data_i    = '0;
        clear_logs();

        test_reset();
        test_full_load();
        test_partial();
        test_empty();
        test_clamp();
        test_abort();
        test_wrap();
        test_reset_mid_load();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clause_bin_loader.md
Name: clause_bin_loader

Overview:
- Write-side driver for the clause array.
- On a start pulse, fetches a bin's clauses one word at a time from global clause memory over a request/valid interface.
- Writes each fetched clause into its clause-array slot using the one-hot write strobe, length and variable-value bus that the clause array consumes.
- Zero-fills any unused slots so every slot of the bin is written before done is raised.

Parameters:
- NUM_CLAUSES_A_BIN, 4: clause slots per bin; width of wr_o.
- NUM_VARS_A_BIN, 8: variables per bin; each variable is 3 bits on var_value_o.
- WIDTH_C_LEN, 5: clause length field width.
- WIDTH_CIDX, 3: clause index/count width; must hold 0..NUM_CLAUSES_A_BIN.
- WIDTH_ADDR, 16: global clause memory word address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle load request; sampled only in IDLE.
- abort_i  in  1  synchronous cancel; takes priority over every other input.
- base_addr_i  in  WIDTH_ADDR  memory address of the bin's first clause; latched on start.
- num_clauses_i  in  WIDTH_CIDX  valid clauses in the bin; latched on start.
- mem_rd_o  out  1  one-cycle read request.
- mem_addr_o  out  WIDTH_ADDR  read address, valid while mem_rd_o=1.
- mem_valid_i  in  1  read data valid.
- mem_data_i  in  NUM_VARS_A_BIN*3+WIDTH_C_LEN  {var_values, clause_len}; var_values in the MSBs.
- wr_o  out  NUM_CLAUSES_A_BIN  one-hot slot write strobe to the clause array.
- clause_len_o  out  WIDTH_C_LEN  length of the clause being written.
- var_value_o  out  NUM_VARS_A_BIN*3  literal states of the clause being written.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; idx=0. All outputs are 0: wr_o, mem_rd_o, mem_addr_o, clause_len_o, var_value_o, busy_o, done_o.
- All outputs are registered.

State machine states: IDLE, REQ, WAIT, WRITE, CLEAR, DONE.
- IDLE, start_i=1:
  - Latch base_addr_i.
  - Latch n = min(num_clauses_i, NUM_CLAUSES_A_BIN).
  - Set idx=0.
  - Go to REQ if n>0, otherwise go to CLEAR.
- REQ: mem_rd_o=1 and mem_addr_o=base+idx for exactly one cycle, then WAIT. Address arithmetic is modulo 2^WIDTH_ADDR, so the address wraps silently.
- WAIT:
  - Hold until mem_valid_i=1 (earliest one cycle after REQ; no timeout).
  - On valid, register mem_data_i and go to WRITE.
  - mem_valid_i is ignored in every other state.
- WRITE:
  - Drive wr_o=1<<idx, clause_len_o and var_value_o from the registered data for one cycle.
  - Then idx=idx+1. Next state: REQ if idx<n; else CLEAR if idx<NUM_CLAUSES_A_BIN; else DONE.
- CLEAR:
  - Drive wr_o=1<<idx with clause_len_o=0 and var_value_o=0 for one cycle.
  - Then idx=idx+1. Next state: DONE once idx reaches NUM_CLAUSES_A_BIN, otherwise stay in CLEAR.
- DONE: done_o=1 for one cycle, then IDLE.

Output rules:
- wr_o is all-zero outside WRITE/CLEAR.
- wr_o is never multi-hot.
- clause_len_o and var_value_o are 0 whenever wr_o=0.
- Each slot is written exactly once per load, in ascending index order.

Latency:
- Start sampled at cycle 0; first REQ at cycle 1.
- Per real clause: 2+L cycles, where L≥1 is the number of WAIT cycles.
- Per cleared slot: 1 cycle.
- DONE: 1 cycle.

Boundary conditions:
- start_i while busy: ignored; latched values are not disturbed.
- abort_i=1 in any state: next cycle state=IDLE, all outputs 0, no done_o. Slots already written are not undone.
- abort_i with start_i in IDLE: abort wins; no load starts.
- A response (mem_valid_i) that arrives after an abort is dropped.
- num_clauses_i > NUM_CLAUSES_A_BIN: clamped; no extra reads are issued.
- rst asserted mid-load: immediate return to reset state; any in-flight mem response is ignored.
- done_o and start_i in the same cycle: start is ignored, because the FSM is in DONE, not IDLE.

Test Plan:
- n=4, base=0x0100, L=1 → reads at 0x100..0x103. wr_o = 0001,0010,0100,1000 with the matching lens. done_o at cycle 13; busy_o high cycles 1..13.
- n=2, base=0x0020, data lens 3 and 5 → two reads. wr_o=0001 (len 3), wr_o=0010 (len 5), then CLEAR writes 0100 and 1000 with len 0 and var 0; then done.
- n=0 → no mem_rd_o. Four CLEAR writes 0001..1000 on cycles 1..4; done_o on cycle 5.
- num_clauses_i=7 → clamped to 4. Exactly four reads and no CLEAR.
- abort_i in the WAIT state of clause 1, with mem_valid_i arriving the next cycle → slot 1 is not written, no done_o, busy_o=0 the cycle after abort. A new start then runs normally.
- base=0xFFFF, n=2 → addresses 0xFFFF then 0x0000. A start_i pulse mid-load is ignored. Asserting rst=0 mid-WRITE zeroes all outputs immediately.
